stream_arb_mux: RTL and testbench



---
 rtl/stream_arb_mux.sv | 105 ++++++++++
 tb/tb_stream_arb_mux.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N:1 registered stream multiplexer with built-in arbitration.
//
// Each cycle the arbiter picks at most one valid input channel, using either
// round-robin (MODE=0) or fixed priority with the lowest index winning (MODE=1).
// The winner is loaded into a single output register whenever that register is
// empty or is being drained in the same cycle. Back-to-back beats are
// accepted, so the mux sustains one beat per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   out_data   registered data of the accepted beat
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  downstream ready
module stream_arb_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 8,
  parameter int MODE   = 0,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic              found;
  logic              can_load;
  logic              accept;

  // The output register can take a new beat when it is empty or being drained.
  assign can_load = !out_valid || out_ready;

  // Scan channels starting at rr_ptr (round-robin) or at 0 (fixed priority),
  // wrapping modulo NUM_IN; the first valid channel found wins.
  always_comb begin : arbitrate
    int base;
    int idx;
    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave a value unassigned and infer a latch.
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    found      = 1'b0;
    base       = (MODE == 0) ? int'(rr_ptr) : 0;
    idx        = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = base + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
        grant_data = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // found already implies the granted channel is valid.
  assign accept   = can_load && found;
  assign in_ready = {NUM_IN{rst_n && can_load}} & grant;

  // Output register: reload on accept, otherwise drop valid once drained.
  // out_data/out_sel hold their last value when valid falls.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: start the next search just after the last winner.
  // The explicit wrap keeps it below NUM_IN when NUM_IN is not a power of two.
  // In fixed-priority mode it never leaves 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (MODE == 0 && accept) begin
      rr_ptr <= (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Self-checking bench for stream_arb_mux. Three instances share one clock:
//   index 0: NUM_IN=8, round-robin
//   index 1: NUM_IN=8, fixed priority
//   index 2: NUM_IN=5, round-robin
module tb_stream_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [7:0]  v [3];
  logic [63:0] d [3];
  logic        r [3];

  logic [7:0] ir_a, ir_b;
  logic [4:0] ir_c;
  logic [7:0] od_a, od_b, od_c;
  logic [2:0] os_a, os_b, os_c;
  logic       ov_a, ov_b, ov_c;

  int n_tests = 0;
  int n_fail  = 0;

  stream_arb_mux #(.WIDTH(8), .NUM_IN(8), .MODE(0)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .in_data(d[0]), .in_valid(v[0]), .in_ready(ir_a),
    .out_data(od_a), .out_sel(os_a), .out_valid(ov_a), .out_ready(r[0]));

  stream_arb_mux #(.WIDTH(8), .NUM_IN(8), .MODE(1)) u_fp8 (
    .clk(clk), .rst_n(rst_n), .in_data(d[1]), .in_valid(v[1]), .in_ready(ir_b),
    .out_data(od_b), .out_sel(os_b), .out_valid(ov_b), .out_ready(r[1]));

  stream_arb_mux #(.WIDTH(8), .NUM_IN(5), .MODE(0)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .in_data(d[2][39:0]), .in_valid(v[2][4:0]), .in_ready(ir_c),
    .out_data(od_c), .out_sel(os_c), .out_valid(ov_c), .out_ready(r[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_ir(int k);
    case (k)
      0:       return ir_a;
      1:       return ir_b;
      default: return {3'b000, ir_c};
    endcase
  endfunction

  function automatic logic [7:0] rd_od(int k);
    case (k)
      0:       return od_a;
      1:       return od_b;
      default: return od_c;
    endcase
  endfunction

  function automatic logic [2:0] rd_os(int k);
    case (k)
      0:       return os_a;
      1:       return os_b;
      default: return os_c;
    endcase
  endfunction

  function automatic logic rd_ov(int k);
    case (k)
      0:       return ov_a;
      1:       return ov_b;
      default: return ov_c;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit         m_v  [3];
  logic [7:0] m_d  [3];
  int         m_s  [3];
  int         m_nx [3];   // channel that gets first look in round-robin

  function automatic int n_of(int k);
    return (k == 2) ? 5 : 8;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_d[k] = '0; m_s[k] = 0; m_nx[k] = 0;
    end
  endtask

  // Channel the spec says is granted this cycle, or -1 for none.
  function automatic int model_pick(int k);
    int n;
    int c;
    n = n_of(k);
    if (m_v[k] && !r[k]) return -1;
    for (int j = 0; j < n; j++) begin
      c = (k == 1) ? j : (m_nx[k] + j) % n;
      if (v[k][c]) return c;
    end
    return -1;
  endfunction

  task automatic rand_cycle();
    int g [3];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      v[k] = 8'($urandom);
      if (k == 2) v[k][7:5] = 3'b000;
      d[k] = {$urandom, $urandom};
      r[k] = ($urandom_range(0, 3) != 0);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      g[k] = model_pick(k);
      check($sformatf("rand%0d_in_ready", k), rd_ir(k), (g[k] >= 0) ? (64'd1 << g[k]) : 64'd0);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (g[k] >= 0) begin
        m_v[k]  = 1;
        m_d[k]  = d[k][g[k]*8 +: 8];
        m_s[k]  = g[k];
        m_nx[k] = (g[k] + 1) % n_of(k);
      end else if (r[k]) begin
        m_v[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rand%0d_out_valid", k), rd_ov(k), m_v[k]);
      check($sformatf("rand%0d_out_sel", k), rd_os(k), m_s[k]);
      check($sformatf("rand%0d_out_data", k), rd_od(k), m_d[k]);
    end
    check("rr5_ptr_range", (u_rr5.rr_ptr <= 3'd4), 1);
    check("fp8_ptr_zero", u_fp8.rr_ptr, 0);
  endtask

  // ---------------- directed helpers ----------------
  task automatic fill_data(int k);
    for (int i = 0; i < 8; i++) d[k][i*8 +: 8] = 8'hA0 + 8'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v[k] = '0; r[k] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle on instance k, check in_ready before the edge and the
  // output register after it.
  task automatic step(input string tag, input int k, input logic [7:0] vv, input logic rr,
                      input logic [7:0] e_ir, input logic e_ov, input logic [2:0] e_os,
                      input logic [7:0] e_od);
    @(negedge clk);
    v[k] = vv;
    r[k] = rr;
    #1;
    check({tag, "_in_ready"}, rd_ir(k), e_ir);
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, rd_ov(k), e_ov);
    check({tag, "_out_sel"}, rd_os(k), e_os);
    check({tag, "_out_data"}, rd_od(k), e_od);
  endtask

  typedef struct {
    logic [7:0] valid;
    logic       ready;
    logic [7:0] exp_ir;
    logic       exp_ov;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{8'h20, 1'b1, 8'h20, 1'b1, 3'd5};  // ch5 -> pointer 6
    tbl[1]  = '{8'h82, 1'b1, 8'h80, 1'b1, 3'd7};  // search 6,7: ch7 wins
    tbl[2]  = '{8'h82, 1'b1, 8'h02, 1'b1, 3'd1};  // wrap to ch1
    tbl[3]  = '{8'h82, 1'b1, 8'h80, 1'b1, 3'd7};  // pointer 2 -> ch7
    tbl[4]  = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd7};  // stall holds
    tbl[5]  = '{8'h01, 1'b0, 8'h00, 1'b1, 3'd7};  // stall blocks ch0
    tbl[6]  = '{8'h01, 1'b1, 8'h01, 1'b1, 3'd0};  // drain + reload
    tbl[7]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};  // drain, nothing new
    tbl[8]  = '{8'hFF, 1'b0, 8'h02, 1'b1, 3'd1};  // empty reg loads from ptr 1
    tbl[9]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd1};  // full + stalled
    tbl[10] = '{8'h09, 1'b1, 8'h08, 1'b1, 3'd3};  // from ptr 2 -> ch3
    tbl[11] = '{8'h09, 1'b1, 8'h01, 1'b1, 3'd0};  // from ptr 4 -> wraps to ch0

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v[k] = '0; d[k] = '0; r[k] = 1'b0;
    end
    model_reset();

    // Reset state, with inputs asserting valid to prove in_ready is gated.
    @(negedge clk);
    v[0] = 8'hFF; v[1] = 8'hFF; v[2] = 8'h1F;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d_out_valid", k), rd_ov(k), 0);
      check($sformatf("reset%0d_out_data", k), rd_od(k), 0);
      check($sformatf("reset%0d_out_sel", k), rd_os(k), 0);
      check($sformatf("reset%0d_in_ready", k), rd_ir(k), 0);
    end
    do_reset();

    // Table: sparse round-robin with wrap, stalls, drain/reload.
    fill_data(0);
    for (int i = 0; i < 12; i++)
      step($sformatf("tbl%0d", i), 0, tbl[i].valid, tbl[i].ready, tbl[i].exp_ir,
           tbl[i].exp_ov, tbl[i].exp_sel, 8'hA0 + 8'(tbl[i].exp_sel));

    // Round-robin fairness, all eight channels continuously valid.
    do_reset();
    for (int i = 0; i < 10; i++)
      step("rr8_fair", 0, 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), 8'hA0 + 8'(i % 8));

    // Asynchronous reset while a beat is held.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov_a, 0);
    check("midrst_out_data", od_a, 0);
    check("midrst_out_sel", os_a, 0);
    check("midrst_in_ready", ir_a, 0);
    @(posedge clk);
    #1;
    check("midrst_held_valid", ov_a, 0);
    check("midrst_held_ready", ir_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", ir_a, 8'h01);
    @(posedge clk);
    #1;
    check("postrst_out_sel", os_a, 0);
    check("postrst_out_valid", ov_a, 1);
    check("postrst_out_data", od_a, 8'hA0);

    // Backpressure on a single channel.
    do_reset();
    d[0][31:24] = 8'h5C;
    step("bp_load", 0, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 8'h5C);
    for (int i = 0; i < 4; i++)
      step("bp_stall", 0, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3, 8'h5C);
    step("bp_drain", 0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd3, 8'h5C);

    // Fixed priority: ch2 beats ch5 until it withdraws.
    do_reset();
    fill_data(1);
    for (int i = 0; i < 4; i++)
      step("fp_ch2", 1, 8'h24, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA2);
    step("fp_ch5", 1, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5);

    // Five-channel round-robin wraps at 4, then output empties in one cycle.
    do_reset();
    fill_data(2);
    d[2][63:40] = '0;
    for (int i = 0; i < 6; i++)
      step("rr5_cycle", 2, 8'h1F, 1'b1, 8'(1 << (i % 5)), 1'b1, 3'(i % 5), 8'hA0 + 8'(i % 5));
    step("rr5_idle", 2, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'hA0);

    // Randomized traffic against the reference model on all instances.
    do_reset();
    for (int i = 0; i < 2000; i++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
